config_ram_requester: RTL and testbench
=======================================

Name: config_ram_requester

Overview:
- Initiator side of the config RAM port. Accepts single-beat read/write commands over a valid/ready request channel and drives the RAM's wdata/addr/byte_en/wen/ren lines.
- Honours the RAM's busy stall and returns read data over a valid/ready response channel.
- Sits between config-register clients (CSR/debug logic) and config_ram_wrapper.
- Optionally zero-fills the whole RAM after reset.

Parameters:
- N_BYTES, 4, RAM word width in bytes.
- DEPTH, 256, number of RAM words.
- ADDR_BITS, $clog2(DEPTH), address width.
- N_BITS, N_BYTES*8, data width.

Ports:
- CLK  input  1  clock.
- nRST  input  1  reset, asynchronous, active-low.
- req_valid  input  1  command present.
- req_ready  output  1  command accepted when high with req_valid.
- req_wen  input  1  1 = write, 0 = read.
- req_addr  input  ADDR_BITS  word address.
- req_wdata  input  N_BITS  write data.
- req_byte_en  input  N_BYTES  write byte enables.
- rsp_valid  output  1  read data available.
- rsp_ready  input  1  consumer takes rsp_rdata.
- rsp_rdata  output  N_BITS  read data.
- init_done  output  1  RAM ready for commands.
- ram_wdata  output  N_BITS  to RAM wdata.
- ram_addr  output  ADDR_BITS  to RAM addr.
- ram_byte_en  output  N_BYTES  to RAM byte_en.
- ram_wen  output  1  to RAM wen.
- ram_ren  output  1  to RAM ren.
- ram_rdata  input  N_BITS  from RAM rdata.
- ram_busy  input  1  from RAM busy.

Behaviour:
- One clock and one reset: CLK, plus nRST (asynchronous, active-low). No other clock or reset.
- RAM protocol:
  - A RAM access is presented by holding ram_wen or ram_ren high with stable addr/wdata/byte_en.
  - The access completes in the first cycle where ram_busy = 0.
  - For reads, ram_rdata is sampled in that cycle.
  - ram_wen and ram_ren are never both high.
- States: INIT, IDLE, ACCESS, RESP.
- Reset (nRST low): asynchronously force all of the following to 0, effective immediately including mid-access:
  - ram_wen, ram_ren, rsp_valid, ram_addr, ram_wdata, ram_byte_en, rsp_rdata.
  - Internal command registers.
  - The init counter.
- Reset state is INIT if the feature is enabled, otherwise IDLE.
- Any in-flight command or pending response is discarded by reset.
- req_ready = (state == IDLE). init_done = 1 in every state except INIT.
- IDLE:
  - On req_valid && req_ready, register wen/addr/wdata/byte_en, then go to ACCESS.
  - For reads, ram_byte_en is driven all-ones.
- ACCESS:
  - Drive ram_wen = reg_wen and ram_ren = !reg_wen from registers; hold them while ram_busy = 1, with no cycle limit.
  - When ram_busy = 0 on a write, go to IDLE.
  - When ram_busy = 0 on a read, capture ram_rdata into rsp_rdata, set rsp_valid, and go to RESP.
  - ram_wen/ram_ren deassert in the cycle after completion.
- RESP:
  - Hold rsp_valid and rsp_rdata stable until rsp_ready.
  - On rsp_ready, clear rsp_valid and go to IDLE.
  - If rsp_ready is already high on RSP entry, rsp_valid is high for exactly 1 cycle.
- Latency with a zero-latency RAM (busy always 0), accept at cycle 0:
  - Write: ram_wen high in cycle 1, req_ready high again in cycle 2.
  - Read: ram_ren high in cycle 1, rsp_valid high in cycle 2. With rsp_ready = 1, req_ready is high in cycle 3.
- Each extra busy cycle adds one cycle to these figures.
- One outstanding command at most; no pipelining.
- Out-of-range addresses (>= DEPTH) are passed through unchecked.
- Writes produce no response.
- Inputs are sampled only on acceptance; later changes to req_* have no effect.

Optional Feature:
- Macro: CONFIG_RAM_INIT_EN.
- Defined:
  - After reset the block starts in INIT.
  - It writes 0 to every address 0..DEPTH-1 in ascending order: ram_wen = 1, ram_byte_en all-ones, ram_wdata = 0.
  - Each address is held until ram_busy = 0, then the counter advances.
  - The end is detected by compare against DEPTH-1, not by counter wrap, so DEPTH need not be a power of 2.
  - After the last write completes, go to IDLE; init_done rises the following cycle.
  - req_ready = 0 throughout INIT.
  - Reset during INIT restarts the fill from address 0.
- Undefined: no INIT state. The block resets into IDLE with init_done = 1, and req_ready = 1 from the first cycle out of reset.

Test Plan:
- Zero-latency RAM (ram_busy = 0): write addr 0x05, data 0xDEADBEEF, byte_en 0xF, then read addr 0x05 -> ram_wen for 1 cycle at addr 0x05; rsp_valid 2 cycles after read accept; rsp_rdata = 0xDEADBEEF.
- Partial write: write 0x11223344 with byte_en 0xF, then 0xAABBCCDD with byte_en 0x3, then read the same address -> 0x1122CCDD; ram_byte_en for the read = 0xF.
- Busy stall: ram_busy held high 3 cycles on a read -> ram_ren and ram_addr stable for 4 cycles; req_ready low throughout; rsp_valid the cycle after busy drops.
- Response backpressure: rsp_ready low 5 cycles, req_valid high with a new command -> rsp_valid and rsp_rdata held for 5 cycles; the new command is not accepted until the cycle after rsp_ready rises.
- Reset mid-access: assert nRST low during ACCESS with ram_busy = 1 -> ram_ren and rsp_valid fall asynchronously; after release the block is in IDLE (or INIT) and the old command never completes.
- With CONFIG_RAM_INIT_EN, DEPTH = 6, pre-loaded non-zero RAM -> exactly 6 writes to addresses 0..5 with data 0; init_done rises only after the last; every read then returns 0.

Source files
------------

// File: rtl/config_ram_requester.sv
// Initiator for the config RAM port: single-beat read/write commands in, RAM strobes out, read data back.
// Build option CONFIG_RAM_INIT_EN: zero-fill every RAM word after reset before accepting commands.
module config_ram_requester #(
   parameter int N_BYTES   = 4,
   parameter int DEPTH     = 256,
   parameter int ADDR_BITS = $clog2(DEPTH),
   parameter int N_BITS    = N_BYTES*8
) (
   input  logic                 CLK,
   input  logic                 nRST,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_wen,
   input  logic [ADDR_BITS-1:0] req_addr,
   input  logic [N_BITS-1:0]    req_wdata,
   input  logic [N_BYTES-1:0]   req_byte_en,
   output logic                 rsp_valid,
   input  logic                 rsp_ready,
   output logic [N_BITS-1:0]    rsp_rdata,
   output logic                 init_done,
   output logic [N_BITS-1:0]    ram_wdata,
   output logic [ADDR_BITS-1:0] ram_addr,
   output logic [N_BYTES-1:0]   ram_byte_en,
   output logic                 ram_wen,
   output logic                 ram_ren,
   input  logic [N_BITS-1:0]    ram_rdata,
   input  logic                 ram_busy
);

   typedef enum logic [1:0] {INIT, IDLE, ACCESS, RESP} state_t;

`ifdef CONFIG_RAM_INIT_EN
   localparam state_t RST_STATE = INIT;
   localparam logic [ADDR_BITS-1:0] LAST = ADDR_BITS'(DEPTH-1);
   logic [ADDR_BITS-1:0] init_cnt;
`else
   localparam state_t RST_STATE = IDLE;
`endif

   state_t state;
   logic   reg_wen;

   assign req_ready = (state == IDLE);
   assign init_done = (state != INIT);

   // The ram_* output registers double as the command's addr/wdata/byte_en holding registers.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state       <= RST_STATE;
         reg_wen     <= 1'b0;
         ram_wen     <= 1'b0;
         ram_ren     <= 1'b0;
         ram_addr    <= '0;
         ram_wdata   <= '0;
         ram_byte_en <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
`ifdef CONFIG_RAM_INIT_EN
         init_cnt    <= '0;
`endif
      end else begin
         case (state)
`ifdef CONFIG_RAM_INIT_EN
            INIT: begin
               ram_wdata   <= '0;
               ram_byte_en <= '1;
               ram_addr    <= init_cnt;
               if (!ram_wen) begin
                  ram_wen <= 1'b1;
               end else if (!ram_busy) begin
                  // Terminal compare rather than wrap so non-power-of-2 depths stop at DEPTH-1.
                  if (init_cnt == LAST) begin
                     ram_wen <= 1'b0;
                     state   <= IDLE;
                  end else begin
                     init_cnt <= init_cnt + ADDR_BITS'(1);
                     ram_addr <= init_cnt + ADDR_BITS'(1);
                  end
               end
            end
`endif
            IDLE: begin
               if (req_valid) begin
                  reg_wen     <= req_wen;
                  ram_addr    <= req_addr;
                  ram_wdata   <= req_wdata;
                  ram_byte_en <= req_wen ? req_byte_en : '1;
                  ram_wen     <= req_wen;
                  ram_ren     <= !req_wen;
                  state       <= ACCESS;
               end
            end
            ACCESS: begin
               if (!ram_busy) begin
                  ram_wen <= 1'b0;
                  ram_ren <= 1'b0;
                  if (reg_wen) begin
                     state <= IDLE;
                  end else begin
                     rsp_rdata <= ram_rdata;
                     rsp_valid <= 1'b1;
                     state     <= RESP;
                  end
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_config_ram_requester.sv
// Directed bench for config_ram_requester against a small byte-enabled RAM model with a driven busy line.
// Honours CONFIG_RAM_INIT_EN to also check the post-reset zero fill.
module tb_config_ram_requester;
   localparam int N_BYTES   = 4;
   localparam int DEPTH     = 6;
   localparam int ADDR_BITS = $clog2(DEPTH);
   localparam int N_BITS    = N_BYTES*8;

   logic                 CLK = 1'b0;
   logic                 nRST = 1'b0;
   logic                 req_valid, req_ready, req_wen;
   logic [ADDR_BITS-1:0] req_addr;
   logic [N_BITS-1:0]    req_wdata;
   logic [N_BYTES-1:0]   req_byte_en;
   logic                 rsp_valid, rsp_ready;
   logic [N_BITS-1:0]    rsp_rdata;
   logic                 init_done;
   logic [N_BITS-1:0]    ram_wdata;
   logic [ADDR_BITS-1:0] ram_addr;
   logic [N_BYTES-1:0]   ram_byte_en;
   logic                 ram_wen, ram_ren;
   logic [N_BITS-1:0]    ram_rdata;
   logic                 ram_busy;

   logic [N_BITS-1:0]    mem [DEPTH];
   logic [ADDR_BITS-1:0] wr_addr_q [$];
   logic [N_BITS-1:0]    wr_data_q [$];
   int n_chk = 0;
   int n_fail = 0;

   config_ram_requester #(.N_BYTES(N_BYTES), .DEPTH(DEPTH)) dut (
      .CLK(CLK), .nRST(nRST),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_byte_en(req_byte_en),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .init_done(init_done),
      .ram_wdata(ram_wdata), .ram_addr(ram_addr), .ram_byte_en(ram_byte_en),
      .ram_wen(ram_wen), .ram_ren(ram_ren), .ram_rdata(ram_rdata), .ram_busy(ram_busy)
   );

   always #5 CLK = ~CLK;

   assign ram_rdata = (int'(ram_addr) < DEPTH) ? mem[int'(ram_addr)] : '0;

   always @(posedge CLK) begin
      if (nRST && ram_wen && !ram_busy && int'(ram_addr) < DEPTH) begin
         for (int b = 0; b < N_BYTES; b++)
            if (ram_byte_en[b]) mem[int'(ram_addr)][b*8 +: 8] <= ram_wdata[b*8 +: 8];
         wr_addr_q.push_back(ram_addr);
         wr_data_q.push_back(ram_wdata);
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   // Returns one cycle after the accepting edge (first ACCESS cycle).
   task automatic issue(input logic wen, input logic [ADDR_BITS-1:0] a,
                        input logic [31:0] d, input logic [3:0] be);
      req_valid = 1'b1; req_wen = wen; req_addr = a; req_wdata = d; req_byte_en = be;
      for (int i = 0; i < 200 && !req_ready; i++) step();
      chk("accept_ready", 32'(req_ready), 1);
      step();
      req_valid = 1'b0;
   endtask

   task automatic do_read(input string tag, input logic [ADDR_BITS-1:0] a, input logic [31:0] exp);
      rsp_ready = 1'b1;
      issue(1'b0, a, 32'h0, 4'h0);
      chk({tag, "_ren"}, 32'(ram_ren), 1);
      chk({tag, "_wen"}, 32'(ram_wen), 0);
      chk({tag, "_addr"}, 32'(ram_addr), 32'(a));
      chk({tag, "_be"}, 32'(ram_byte_en), 32'hF);
      step();
      chk({tag, "_rvalid"}, 32'(rsp_valid), 1);
      chk({tag, "_rdata"}, rsp_rdata, exp);
      chk({tag, "_ren_off"}, 32'(ram_ren), 0);
      step();
      chk({tag, "_rvalid_off"}, 32'(rsp_valid), 0);
      chk({tag, "_ready_back"}, 32'(req_ready), 1);
   endtask

   task automatic reset_release();
      @(negedge CLK);
      wr_addr_q.delete();
      wr_data_q.delete();
      nRST = 1'b1;
      step();
   endtask

   task automatic wait_init();
      for (int i = 0; i < 500 && !init_done; i++) step();
      chk("init_done", 32'(init_done), 1);
      chk("init_writes", wr_addr_q.size(), DEPTH);
      for (int i = 0; i < wr_addr_q.size() && i < DEPTH; i++) begin
         chk("init_addr", 32'(wr_addr_q[i]), i);
         chk("init_data", wr_data_q[i], 0);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA5A5_0000 | i;
      req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0; req_byte_en = '0;
      rsp_ready = 1'b1; ram_busy = 1'b0;
      #12;
      chk("rst_wen", 32'(ram_wen), 0);
      chk("rst_ren", 32'(ram_ren), 0);
      chk("rst_rvalid", 32'(rsp_valid), 0);
      chk("rst_addr", 32'(ram_addr), 0);
      chk("rst_wdata", ram_wdata, 0);
      chk("rst_be", 32'(ram_byte_en), 0);
      chk("rst_rdata", rsp_rdata, 0);
`ifdef CONFIG_RAM_INIT_EN
      chk("rst_init_done", 32'(init_done), 0);
      chk("rst_ready", 32'(req_ready), 0);
      reset_release();
      // Stall the first fill word to check it is held.
      chk("init_first_wen", 32'(ram_wen), 1);
      chk("init_first_addr", 32'(ram_addr), 0);
      chk("init_busy_ready", 32'(req_ready), 0);
      ram_busy = 1'b1;
      step();
      chk("init_hold_wen", 32'(ram_wen), 1);
      chk("init_hold_addr", 32'(ram_addr), 0);
      step();
      chk("init_hold_cnt", wr_addr_q.size(), 0);
      chk("init_hold_done", 32'(init_done), 0);
      ram_busy = 1'b0;
      wait_init();
      for (int i = 0; i < DEPTH; i++) do_read("init_rd", ADDR_BITS'(i), 32'h0);
`else
      chk("rst_init_done", 32'(init_done), 1);
      chk("rst_ready", 32'(req_ready), 1);
      reset_release();
      chk("out_ready", 32'(req_ready), 1);
      chk("out_init_done", 32'(init_done), 1);
`endif

      // Zero-latency write then read back.
      issue(1'b1, 3'h5, 32'hDEADBEEF, 4'hF);
      chk("wr_wen", 32'(ram_wen), 1);
      chk("wr_ren", 32'(ram_ren), 0);
      chk("wr_addr", 32'(ram_addr), 5);
      chk("wr_wdata", ram_wdata, 32'hDEADBEEF);
      chk("wr_be", 32'(ram_byte_en), 32'hF);
      chk("wr_ready_low", 32'(req_ready), 0);
      step();
      chk("wr_wen_off", 32'(ram_wen), 0);
      chk("wr_ready_back", 32'(req_ready), 1);
      chk("wr_no_rsp", 32'(rsp_valid), 0);
      do_read("rd0", 3'h5, 32'hDEADBEEF);

      // Byte-enable merge.
      issue(1'b1, 3'h4, 32'h11223344, 4'hF);
      step();
      issue(1'b1, 3'h4, 32'hAABBCCDD, 4'h3);
      chk("pw_be", 32'(ram_byte_en), 32'h3);
      step();
      do_read("pw_rd", 3'h4, 32'h1122CCDD);

      // Busy stall: three busy cycles on a read.
      ram_busy = 1'b1;
      issue(1'b0, 3'h4, 32'h0, 4'h0);
      for (int k = 0; k < 3; k++) begin
         chk("st_ren", 32'(ram_ren), 1);
         chk("st_addr", 32'(ram_addr), 4);
         chk("st_ready", 32'(req_ready), 0);
         chk("st_rvalid", 32'(rsp_valid), 0);
         step();
      end
      ram_busy = 1'b0;
      chk("st_ren_last", 32'(ram_ren), 1);
      chk("st_addr_last", 32'(ram_addr), 4);
      step();
      chk("st_rvalid_on", 32'(rsp_valid), 1);
      chk("st_rdata", rsp_rdata, 32'h1122CCDD);
      chk("st_ren_off", 32'(ram_ren), 0);
      step();
      chk("st_rvalid_off", 32'(rsp_valid), 0);

      // Response backpressure with a queued write behind it.
      rsp_ready = 1'b0;
      issue(1'b0, 3'h5, 32'h0, 4'h0);
      req_valid = 1'b1; req_wen = 1'b1; req_addr = 3'h2; req_wdata = 32'h0BADF00D; req_byte_en = 4'hF;
      step();
      for (int k = 0; k < 5; k++) begin
         chk("bp_rvalid", 32'(rsp_valid), 1);
         chk("bp_rdata", rsp_rdata, 32'hDEADBEEF);
         chk("bp_ready", 32'(req_ready), 0);
         step();
      end
      rsp_ready = 1'b1;
      chk("bp_rvalid_hs", 32'(rsp_valid), 1);
      chk("bp_ready_hs", 32'(req_ready), 0);
      step();
      chk("bp_rvalid_off", 32'(rsp_valid), 0);
      chk("bp_ready_on", 32'(req_ready), 1);
      chk("bp_not_yet", 32'(ram_wen), 0);
      step();
      req_valid = 1'b0; req_wdata = 32'h12345678;
      chk("bp_new_wen", 32'(ram_wen), 1);
      chk("bp_new_addr", 32'(ram_addr), 2);
      chk("bp_new_wdata", ram_wdata, 32'h0BADF00D);
      step();
      chk("bp_new_done", 32'(ram_wen), 0);
      do_read("bp_rd", 3'h2, 32'h0BADF00D);

      // Reset while a response is pending.
      rsp_ready = 1'b0;
      issue(1'b0, 3'h2, 32'h0, 4'h0);
      step();
      chk("rr_rvalid_pre", 32'(rsp_valid), 1);
      nRST = 1'b0;
      #1;
      chk("rr_rvalid_async", 32'(rsp_valid), 0);
      chk("rr_rdata_async", rsp_rdata, 0);
      rsp_ready = 1'b1;
      reset_release();
`ifdef CONFIG_RAM_INIT_EN
      wait_init();
`endif

      // Reset mid-access with the RAM stalled.
      ram_busy = 1'b1;
      issue(1'b0, 3'h5, 32'h0, 4'h0);
      chk("ra_ren_pre", 32'(ram_ren), 1);
      step();
      nRST = 1'b0;
      #1;
      chk("ra_ren_async", 32'(ram_ren), 0);
      chk("ra_rvalid_async", 32'(rsp_valid), 0);
      chk("ra_addr_async", 32'(ram_addr), 0);
      ram_busy = 1'b0;
      reset_release();
`ifdef CONFIG_RAM_INIT_EN
      wait_init();
`else
      chk("ra_ready", 32'(req_ready), 1);
`endif
      for (int k = 0; k < 3; k++) begin
         chk("ra_no_rvalid", 32'(rsp_valid), 0);
         chk("ra_no_ren", 32'(ram_ren), 0);
         step();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
